// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types and helpers for the data-memory arbiter.
//   - arb_state_e : ownership FSM encoding (no owner / locked to m0 / locked to m1)
//   - M_CPU/M_DBG : master indices (m0 = CPU load/store, m1 = debug/loader)
//   - err_code_e  : address-check outcome
//   - mreq_t      : one master's request bundle
//   - mrsp_t      : one master's registered response bundle
//   - addr_check(): alignment / range classification of a byte address
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;
    localparam int unsigned NUM_M = 2;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2
    } err_code_e;

    typedef struct packed {
        logic        req;
        logic        we;
        logic        lock;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct packed {
        logic        rvalid;
        logic        err;
        logic [31:0] rdata;
    } mrsp_t;

    // Word accesses only: low two bits must be zero and the byte address
    // must fall inside the 4*depth byte window.
    function automatic err_code_e addr_check(input logic [31:0] addr,
                                             input int unsigned depth);
        logic [31:0] limit;
        limit = 32'(depth) << 2;
        if (addr[1:0] != 2'b00) return ERR_MISALIGN;
        if (addr >= limit)      return ERR_RANGE;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: pure combinational two-way round-robin picker.
//   req_i[1:0] : request vector
//   last_i     : index of the master granted most recently
//   gnt_o[1:0] : one-hot (or zero) grant; on a tie the master that was
//                NOT granted last wins.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    assign gnt_o[0] = req_i[0] & (~req_i[1] |  last_i);
    assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single Data_Memory port between the CPU (m0) and
// the debug/loader port (m1).
//   m{0,1}_req_i/we_i/lock_i/addr_i/wdata_i : request, held until granted
//   m{0,1}_gnt_o                            : combinational grant, access happens this cycle
//   m{0,1}_rvalid_o/rdata_o/err_o           : registered response, one cycle after grant
//   mem_addr_o/mem_wdata_o/mem_we_o/mem_re_o: drive Data_Memory (word index)
//   mem_rdata_i                             : combinational read data from Data_Memory
// Round robin between the two masters; a master holding lock keeps the port
// for at most MAX_HOLD consecutive grants, then is forced back to arbitration
// with itself marked as last so the other side wins the next tie.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic          clk_i,
    input  logic          rst_n,

    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic          m0_lock_i,
    input  logic [31:0]   m0_addr_i,
    input  logic [31:0]   m0_wdata_i,
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,
    output logic [31:0]   m0_rdata_o,
    output logic          m0_err_o,

    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic          m1_lock_i,
    input  logic [31:0]   m1_addr_i,
    input  logic [31:0]   m1_wdata_i,
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,
    output logic [31:0]   m1_rdata_o,
    output logic          m1_err_o,

    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic          mem_we_o,
    output logic          mem_re_o,
    input  logic [31:0]   mem_rdata_i
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    mreq_t [NUM_M-1:0] req_s;
    logic  [NUM_M-1:0] req_v;
    logic  [NUM_M-1:0] pick_gnt;
    logic  [NUM_M-1:0] gnt;

    arb_state_e    state_q, state_d;
    logic          last_q, last_d;
    logic [HW-1:0] hold_q, hold_d, hold_inc;

    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;

    mrsp_t [NUM_M-1:0] rsp_q, rsp_d;

    logic      any_gnt;
    logic      gsel;
    mreq_t     sel;
    err_code_e ecode;
    logic      bad;
    logic      acc_ok;

    assign req_s[M_CPU] = {m0_req_i, m0_we_i, m0_lock_i, m0_addr_i, m0_wdata_i};
    assign req_s[M_DBG] = {m1_req_i, m1_we_i, m1_lock_i, m1_addr_i, m1_wdata_i};

    for (genvar i = 0; i < NUM_M; i++) begin : g_req
        assign req_v[i] = req_s[i].req;
    end

    rr_pick2 u_pick (
        .req_i  (req_v),
        .last_i (last_q),
        .gnt_o  (pick_gnt)
    );

    // Grant: picker only when nobody owns the port; an owner is granted
    // whenever it requests and the other master is shut out.
    // Held at zero while reset is asserted so nothing reaches memory.
    always_comb begin
        gnt = '0;
        unique case (state_q)
            ST_IDLE: gnt = pick_gnt;
            ST_OWN0: gnt[M_CPU] = req_v[M_CPU];
            ST_OWN1: gnt[M_DBG] = req_v[M_DBG];
            default: gnt = '0;
        endcase
        if (!rst_n) gnt = '0;
    end

    assign any_gnt = |gnt;
    assign gsel    = gnt[M_DBG];
    assign sel     = req_s[gsel];
    assign ecode   = addr_check(sel.addr, DEPTH);
    assign bad     = (ecode != ERR_NONE);
    assign acc_ok  = any_gnt & ~bad;

    assign m0_gnt_o = gnt[M_CPU];
    assign m1_gnt_o = gnt[M_DBG];

    // Faulting accesses never touch memory; address/data buses keep their
    // last driven value when no real access happens.
    assign mem_we_o    = acc_ok &  sel.we;
    assign mem_re_o    = acc_ok & ~sel.we;
    assign mem_addr_o  = acc_ok ? sel.addr[AW+1:2] : addr_q;
    assign mem_wdata_o = acc_ok ? sel.wdata        : wdata_q;

    // Ownership / hold-count next state. hold counts consecutive locked
    // grants including the one that opened the burst.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        hold_d   = hold_q;
        hold_inc = hold_q + HW'(1);
        if (any_gnt) begin
            last_d = gsel;
            if (sel.lock) begin
                if (hold_inc >= HW'(MAX_HOLD)) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end else begin
                    state_d = gsel ? ST_OWN1 : ST_OWN0;
                    hold_d  = hold_inc;
                end
            end else begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        end else begin
            state_d = ST_IDLE;
            hold_d  = '0;
        end
    end

    // Response for each master reflects only its own grant of this cycle.
    always_comb begin
        for (int i = 0; i < NUM_M; i++) begin
            rsp_d[i].rvalid = gnt[i];
            rsp_d[i].err    = gnt[i] & bad;
            rsp_d[i].rdata  = (gnt[i] & acc_ok & ~sel.we) ? mem_rdata_i : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            hold_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            rsp_q   <= rsp_d;
            if (acc_ok) begin
                addr_q  <= sel.addr[AW+1:2];
                wdata_q <= sel.wdata;
            end
        end
    end

    assign m0_rvalid_o = rsp_q[M_CPU].rvalid;
    assign m0_err_o    = rsp_q[M_CPU].err;
    assign m0_rdata_o  = rsp_q[M_CPU].rdata;
    assign m1_rvalid_o = rsp_q[M_DBG].rvalid;
    assign m1_err_o    = rsp_q[M_DBG].err;
    assign m1_rdata_o  = rsp_q[M_DBG].rdata;

endmodule
